speaker_capture: RTL and testbench

- Master-mode serial audio receiver: the capture side of the team's 16-bit stereo serial audio link.
- Generates mclk, sck and lrck from the system clock and deserialises the ADC serial output into 16-bit left/right words.
- Presents each stereo frame on a valid/ready interface with a sticky overrun flag.
- Sits between the line-in/mic ADC pins and downstream audio processing.

---
 rtl/speaker_capture.sv | 126 ++++++++++++
 tb/tb_speaker_capture.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speaker_capture.sv
// speaker_capture: master-mode serial audio receiver (capture side of the
// 16-bit stereo serial audio link).
//
// Derives mclk/sck/lrck from the system clock with one free-running 9-bit
// divider. It deserialises the ADC serial stream into left/right words and
// hands each stereo frame downstream on a valid/ready interface with a sticky
// overrun flag.
//
// Parameters:
//   DATA_DELAY       slot offset of the MSB after an lrck edge
//                    (0 = left-justified, 1 = I2S; only 0 and 1 are legal)
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   audio_sdout      serial data from the ADC (launched on sck falling edge)
//   audio_mclk       master clock, clk/4
//   audio_sck        bit clock, clk/16
//   audio_lrck       word select, clk/512 (0 = left half, 1 = right half)
//   audio_out_left   captured left sample (two's complement)
//   audio_out_right  captured right sample (two's complement)
//   sample_valid     a captured frame is available
//   sample_ready     consumer accepts the frame
//   overrun          sticky: a frame was overwritten before being accepted
module speaker_capture #(
  parameter int DATA_DELAY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        audio_sdout,
  output logic        audio_mclk,
  output logic        audio_sck,
  output logic        audio_lrck,
  output logic [15:0] audio_out_left,
  output logic [15:0] audio_out_right,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun
);

  localparam logic [4:0] DELAY_SLOTS = 5'(DATA_DELAY);

  logic [8:0]  r_div;
  logic        r_sd;
  logic [15:0] r_left_sr;
  // The right LSB (k == 31) goes straight into the output word from r_sd,
  // so only the upper 15 right bits need storage.
  logic [14:0] r_right_sr;
  logic        r_primed;
  logic [15:0] r_left;
  logic [15:0] r_right;
  logic        r_valid;
  logic        r_overrun;

  logic [4:0]  w_slot;
  logic [4:0]  w_k;
  logic        w_capture;
  logic        w_complete;
  logic        w_transfer;

  assign w_slot     = r_div[8:4];
  assign w_k        = w_slot - DELAY_SLOTS;   // wraps mod 32
  // One clk after the sck rising edge r_sd holds the pin sampled at that edge.
  assign w_capture  = (r_div[3:0] == 4'd9);
  assign w_complete = w_capture && (w_k == 5'd31) && r_primed;
  assign w_transfer = r_valid && sample_ready;

  // Clock outputs come straight from divider register bits (glitch-free).
  assign audio_mclk = r_div[1];
  assign audio_sck  = r_div[3];
  assign audio_lrck = r_div[8];

  assign audio_out_left  = r_left;
  assign audio_out_right = r_right;
  assign sample_valid    = r_valid;
  assign overrun         = r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_sd  <= 1'b0;
    end else begin
      r_div <= r_div + 9'd1;
      r_sd  <= audio_sdout;
    end
  end

  // Deserialiser; priming waits for a word start so the first frame after
  // reset is never built from a partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_left_sr  <= '0;
      r_right_sr <= '0;
      r_primed   <= 1'b0;
    end else if (w_capture) begin
      if (!w_k[4]) begin
        r_left_sr <= {r_left_sr[14:0], r_sd};
      end else if (w_k != 5'd31) begin
        r_right_sr <= {r_right_sr[13:0], r_sd};
      end
      if (w_k == 5'd0) begin
        r_primed <= 1'b1;
      end
    end
  end

  // Output registers and handshake. A completion always wins over a transfer
  // in the same cycle: the new frame loads and valid stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_left    <= '0;
      r_right   <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_complete) begin
      r_left  <= r_left_sr;
      r_right <= {r_right_sr, r_sd};
      r_valid <= 1'b1;
      if (r_valid && !sample_ready) begin
        r_overrun <= 1'b1;
      end
    end else if (w_transfer) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_speaker_capture.sv
module tb_speaker_capture;

  logic        clk;
  logic        rst_n;

  logic        sd0, sd1;
  logic        ready0, ready1;
  logic        mclk0, mclk1, sck0, sck1, lrck0, lrck1;
  logic [15:0] left0, left1, right0, right1;
  logic        valid0, valid1, ovr0, ovr1;

  speaker_capture #(.DATA_DELAY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .audio_sdout(sd0),
    .audio_mclk(mclk0), .audio_sck(sck0), .audio_lrck(lrck0),
    .audio_out_left(left0), .audio_out_right(right0),
    .sample_valid(valid0), .sample_ready(ready0), .overrun(ovr0)
  );

  speaker_capture #(.DATA_DELAY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .audio_sdout(sd1),
    .audio_mclk(mclk1), .audio_sck(sck1), .audio_lrck(lrck1),
    .audio_out_left(left1), .audio_out_right(right1),
    .sample_valid(valid1), .sample_ready(ready1), .overrun(ovr1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int edges   = 0;
  int rel     = 0;
  int first0  = -1;
  int first1  = -1;
  int rises0  = 0;
  int rises1  = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  // ADC model state: frame to send ({left, right}) and per-instance shifter
  logic [31:0] adc_frame = 32'h0;
  logic [31:0] tx[2]     = '{32'h0, 32'h0};
  int          pos[2]    = '{0, 0};
  logic        lrck_q[2] = '{1'b0, 1'b0};
  logic        sck_q[2]  = '{1'b0, 1'b0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      edges++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rel(input int n);
    while (edges - rel < n) @(negedge clk);
  endtask

  // Slave ADC: launches a bit after each sck falling edge; a new word starts at
  // capture index 0, and the I2S right LSB lands in slot 0 of the next frame.
  task automatic adc_step(input int idx, input int dd, input logic cur_sck,
                          input logic cur_lrck, inout logic sd_o);
    logic        launch;
    logic [31:0] w;
    int          g, k;
    launch = !rst_n || (sck_q[idx] && !cur_sck);
    sck_q[idx] = cur_sck;
    if (launch) begin
      if (!rst_n) begin
        pos[idx]    = 0;
        lrck_q[idx] = 1'b0;
      end else begin
        if (cur_lrck != lrck_q[idx]) pos[idx] = 0;
        else pos[idx]++;
        lrck_q[idx] = cur_lrck;
      end
      g = (lrck_q[idx] ? 16 : 0) + pos[idx];
      k = (g - dd) & 31;
      if (k == 0) tx[idx] = adc_frame;
      w = tx[idx];
      sd_o = w[31-k];
    end
  endtask

  initial begin
    sd0 = 1'b0;
    sd1 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      adc_step(0, 0, sck0, lrck0, sd0);
      adc_step(1, 1, sck1, lrck1, sd1);
    end
  end

  // Monitor: pops the scoreboard whenever a transfer is about to happen
  initial begin
    logic        pv0, pv1;
    logic [31:0] e;
    pv0 = 1'b0;
    pv1 = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && valid0 && !pv0) begin
        rises0++;
        if (first0 < 0) first0 = edges;
      end
      if (rst_n && valid1 && !pv1) begin
        rises1++;
        if (first1 < 0) first1 = edges;
      end
      pv0 = valid0;
      pv1 = valid1;
      if (rst_n && valid0 && ready0) begin
        if (q0.size() == 0) check("dut0 unexpected frame", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          check("dut0 left", {16'h0, left0}, {16'h0, e[31:16]});
          check("dut0 right", {16'h0, right0}, {16'h0, e[15:0]});
        end
      end
      if (rst_n && valid1 && ready1) begin
        if (q1.size() == 0) check("dut1 unexpected frame", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          check("dut1 left", {16'h0, left1}, {16'h0, e[31:16]});
          check("dut1 right", {16'h0, right1}, {16'h0, e[15:0]});
        end
      end
    end
  end

  task automatic clock_check();
    logic pm, ps, pl;
    int last_m = -1, last_s = -1, last_l = -1;
    int rm = 0, rs = 0, rl = 0, s_in_l = 0;
    int per_err = 0, coin_err = 0, cnt_err = 0;
    pm = mclk0;
    ps = sck0;
    pl = lrck0;
    for (int t = 1; t <= 2048; t++) begin
      @(negedge clk);
      if (mclk0 && !pm) begin
        if (last_m >= 0 && t - last_m != 4) per_err++;
        last_m = t;
        rm++;
      end
      if (sck0 && !ps) begin
        if (last_s >= 0 && t - last_s != 16) per_err++;
        last_s = t;
        rs++;
        s_in_l++;
      end
      if (lrck0 != pl && !(ps && !sck0)) coin_err++;
      if (lrck0 && !pl) begin
        if (last_l >= 0) begin
          if (t - last_l != 512) per_err++;
          if (s_in_l != 32) cnt_err++;
        end
        last_l = t;
        rl++;
        s_in_l = 0;
      end
      pm = mclk0;
      ps = sck0;
      pl = lrck0;
    end
    check("mclk rises", 32'(rm), 32'd512);
    check("sck rises", 32'(rs), 32'd128);
    check("lrck rises", 32'(rl), 32'd4);
    check("clock period errors", 32'(per_err), 32'd0);
    check("lrck/sck-fall alignment errors", 32'(coin_err), 32'd0);
    check("sck per lrck errors", 32'(cnt_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    ready0    = 1'b1;
    ready1    = 1'b1;
    adc_frame = 32'hA5C3_3C5A;
    repeat (4) @(negedge clk);

    check("reset valid", 32'(valid0), 32'd0);
    check("reset overrun", 32'(ovr0), 32'd0);
    check("reset left", {16'h0, left0}, 32'h0);
    check("reset right", {16'h0, right0}, 32'h0);
    check("reset clocks", 32'({mclk0, sck0, lrck0}), 32'd0);

    q0.push_back(32'hA5C3_3C5A);
    q0.push_back(32'h8000_7FFF);
    q1.push_back(32'hA5C3_3C5A);
    q1.push_back(32'h8000_7FFF);
    rst_n = 1'b1;
    rel   = edges;
    fork
      clock_check();
    join_none

    wait_rel(300);
    adc_frame = 32'h8000_7FFF;
    wait_rel(510);
    check("dut0 first valid edge", 32'(first0 - rel), 32'd506);
    check("dut0 valid pulses", 32'(rises0), 32'd1);
    check("dut0 valid one cycle", 32'(valid0), 32'd0);
    wait_rel(530);
    check("dut1 first valid edge", 32'(first1 - rel), 32'd522);
    check("dut1 valid pulses", 32'(rises1), 32'd1);
    check("dut1 valid one cycle", 32'(valid1), 32'd0);

    wait_rel(800);
    adc_frame = 32'h0001_FFFF;
    wait_rel(1100);
    check("dut0 queue after two frames", 32'(q0.size()), 32'd0);
    check("dut1 queue after two frames", 32'(q1.size()), 32'd0);
    ready0 = 1'b0;
    ready1 = 1'b0;
    wait_rel(1300);
    adc_frame = 32'h1234_5678;
    wait_rel(1540);
    check("held valid", 32'(valid0), 32'd1);
    check("held left", {16'h0, left0}, 32'h0001);
    wait_rel(1800);
    adc_frame = 32'h9ABC_DEF0;

    // ready raised for the cycle whose closing edge completes the next frame
    wait_rel(2041);
    q0.push_back(32'h0001_FFFF);
    ready0 = 1'b1;
    wait_rel(2042);
    ready0 = 1'b0;
    check("simul valid", 32'(valid0), 32'd1);
    check("simul left", {16'h0, left0}, 32'h1234);
    check("simul right", {16'h0, right0}, 32'h5678);
    check("simul overrun", 32'(ovr0), 32'd0);

    wait_rel(2560);
    check("overrun flag", 32'(ovr0), 32'd1);
    check("overrun valid", 32'(valid0), 32'd1);
    check("overrun left", {16'h0, left0}, 32'h9ABC);
    check("overrun right", {16'h0, right0}, 32'hDEF0);
    q0.push_back(32'h9ABC_DEF0);
    ready0 = 1'b1;
    wait_rel(2561);
    ready0 = 1'b0;
    check("post-transfer valid", 32'(valid0), 32'd0);
    check("post-transfer overrun sticky", 32'(ovr0), 32'd1);
    check("post-transfer left hold", {16'h0, left0}, 32'h9ABC);
    check("post-transfer right hold", {16'h0, right0}, 32'hDEF0);

    adc_frame = 32'h4321_8765;
    wait_rel(2760);
    rst_n = 1'b0;
    #1;
    check("midreset valid", 32'(valid0), 32'd0);
    check("midreset overrun", 32'(ovr0), 32'd0);
    check("midreset left", {16'h0, left0}, 32'h0);
    check("midreset right", {16'h0, right0}, 32'h0);
    check("midreset clocks", 32'({mclk0, sck0, lrck0}), 32'd0);
    repeat (5) @(negedge clk);
    q0.push_back(32'h4321_8765);
    ready0 = 1'b1;
    rst_n  = 1'b1;
    rel    = edges;
    first0 = -1;
    rises0 = 0;
    wait_rel(510);
    check("after reset first valid edge", 32'(first0 - rel), 32'd506);
    check("after reset valid pulses", 32'(rises0), 32'd1);
    check("after reset valid one cycle", 32'(valid0), 32'd0);
    wait_rel(520);
    check("dut0 queue drained", 32'(q0.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
